// File: rtl/vga_text_reader.sv
// vga_text_reader: read side of an 80x30 character buffer. The block scans the
// buffer in step with 640x480@60 timing. It fetches each character code from the
// character RAM and its glyph row from an 8x16 font ROM, then serialises the
// glyph bits into RGB332 pixels.
// Pipeline: counters -> stage 1 (RAM data captured) -> stage 2 (output regs).
// Sync, blanking and frame_start travel through the same two stages, so every
// output stays aligned with its pixel. The block has no handshakes: all state
// advances on clk rising edges where ce=1 and holds otherwise.
module vga_text_reader #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 30,
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  FG_COLOR = 8'hFF,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic [10:0]       font_addr,
  input  logic [7:0]        font_data,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        rgb,
  output logic              frame_start
);

  // 640x480@60 raster; the visible area follows from the text geometry (8x16 cells)
  localparam logic [9:0] H_ACTIVE = 10'(COLS * 8);
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] HS_FIRST = 10'd656;
  localparam logic [9:0] HS_LAST  = 10'd751;
  localparam logic [9:0] V_ACTIVE = 10'(ROWS * 16);
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] VS_FIRST = 10'd490;
  localparam logic [9:0] VS_LAST  = 10'd491;

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  // Stage 0 signals, combinational from the counters
  logic       active;
  logic       hs_act;
  logic       vs_act;
  logic [6:0] col;
  logic [4:0] row;

  // Stage 1 registers. The sync flags are stored active-high ("inside the
  // pulse") so an all-zero pipeline after reset cannot emit a sync pulse.
  logic [7:0] s1_char;
  logic [3:0] s1_grow;
  logic [2:0] s1_xbit;
  logic       s1_active;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_fs;

  logic       pix_bit;

  // Raster position: h wraps at 799 and carries into v, which wraps at 524
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign hs_act = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_act = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign col    = h_cnt[9:3];
  assign row    = v_cnt[8:4];

  // Address is parked at 0 during blanking; the largest value (2399) fits ADDR_W
  assign ram_addr = active ? (ADDR_W'(row) * COLS_A + ADDR_W'(col)) : '0;

  // Stage 1: capture the character code and the raster attributes that belong to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_char   <= '0;
      s1_grow   <= '0;
      s1_xbit   <= '0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_fs     <= 1'b0;
    end else if (ce) begin
      s1_char   <= ram_data;
      s1_grow   <= v_cnt[3:0];
      s1_xbit   <= h_cnt[2:0];
      s1_active <= active;
      s1_hs     <= hs_act;
      s1_vs     <= vs_act;
      s1_fs     <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  // Glyph row lookup; the character code's bit 7 is the inverse-video flag, not a glyph index
  assign font_addr = {s1_char[6:0], s1_grow};
  assign pix_bit   = font_data[3'd7 - s1_xbit] ^ s1_char[7];

  // Stage 2: output registers; blanking forces black even for inverse characters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else if (ce) begin
      rgb         <= s1_active ? (pix_bit ? FG_COLOR : BG_COLOR) : 8'h00;
      hsync       <= ~s1_hs;
      vsync       <= ~s1_vs;
      frame_start <= s1_fs;
    end
  end

endmodule
